program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Writer side of the instruction-memory store port: copies a program image word by word from disk (HD) storage into instruction memory.
- Drives the data, address and 3-bit write-control inputs of the instruction memory.
- Sits between the BIOS/OS control logic, which issues start and receives done/error, and the disk read port, which has variable latency.

Parameters:
- MEM_DEPTH, 201, number of instruction-memory words; valid addresses are 0..MEM_DEPTH-1.
- TIMEOUT_CYCLES, 255, maximum number of cycles spent waiting for hd_valid before the load aborts with an error.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset (reset=0 resets at the clock edge).
- start  in  1  load request; sampled only in IDLE.
- abort  in  1  cancels the load in progress.
- src_addr  in  32  first disk word address.
- dst_addr  in  32  first instruction-memory address.
- num_words  in  16  number of words to copy.
- hd_read_en  out  1  one-cycle disk read request.
- hd_addr  out  32  disk read address.
- hd_data  in  32  disk read data.
- hd_valid  in  1  hd_data is valid this cycle.
- instr_data  out  32  word to store.
- instr_addr  out  32  store address.
- instr_wr_ctrl  out  3  3'b001 = write instruction; 3'b000 = no operation.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the load completes.
- error  out  1  one-cycle pulse on timeout or bounds violation.
- words_written  out  16  count of words stored in the current or most recent load.

Behaviour:
- Reset values (reset=0): state IDLE; all outputs 0. This includes instr_wr_ctrl=3'b000, hd_read_en=0 and words_written=0.
- Reset mid-load: the load stops at that edge and no further write is issued.
- States: IDLE, REQ, WAIT, WRITE, DONE, ERR.
- IDLE: when start=1, latch src_addr, dst_addr and num_words, and clear words_written. Then branch:
  - num_words==0 -> DONE.
  - dst_addr+num_words > MEM_DEPTH (compared at 33 bits, no wrap) -> ERR, with no writes.
  - otherwise -> REQ.
- REQ: hd_read_en=1 for exactly one cycle, hd_addr=current source address. Clear the wait timer; next state WAIT.
- WAIT: hd_read_en=0.
  - hd_valid=1 -> capture hd_data, go to WRITE.
  - Otherwise increment the timer; when the timer reaches TIMEOUT_CYCLES -> ERR.
  - hd_valid outside WAIT is ignored.
- WRITE: drive instr_wr_ctrl=3'b001, instr_addr=current destination address and instr_data=captured word for exactly one cycle.
  - Increment source address, destination address and words_written; decrement the remaining count.
  - remaining==0 after the decrement -> DONE; otherwise -> REQ.
- instr_wr_ctrl is 3'b000 in every state except WRITE. instr_addr and instr_data hold their last values.
- DONE: done=1 for one cycle -> IDLE. ERR: error=1 for one cycle -> IDLE.
- Throughput: with hd_valid arriving in the cycle after hd_read_en, one word takes 3 cycles (REQ, WAIT, WRITE).
- start while busy=1 is ignored; no queuing.
- abort=1 in REQ, WAIT or WRITE -> IDLE at the next edge.
  - A write driven in that same WRITE cycle still completes.
  - Neither done nor error pulses; words_written keeps its value.
- abort and start together in IDLE: abort wins and no load starts.
- Address counters are 32 bits and never wrap in practice, because the bounds check runs before any write.

Decomposition:
- Shared package holds:
  - State encoding localparams.
  - Write-control codes WR_NONE=3'b000 and WR_INSTR=3'b001, shared with the instruction memory.
  - Default MEM_DEPTH.
- One sub-module, loader_timeout_timer: clear/enable counter with a TIMEOUT_CYCLES compare that outputs an expired flag.
- The FSM and datapath stay in program_loader.

Test Plan:
- Basic load: start with src=100, dst=0, num_words=4, disk returning 0xA0000000+addr one cycle after each request -> writes to addresses 0..3 with data 0xA0000064..0xA0000067; done pulses at cycle 13 after start; words_written=4.
- Zero length: num_words=0 -> done pulses 1 cycle after the start edge; no hd_read_en and no write.
- Bounds: dst=198, num_words=4 (MEM_DEPTH=201) -> error pulses 1 cycle after start; zero writes. Then dst=197, num_words=4 -> succeeds, last write at address 200.
- Timeout: TIMEOUT_CYCLES=8 and hd_valid never asserted -> error pulses after 8 WAIT cycles; no write; busy returns to 0.
- Abort: num_words=10, abort asserted during the third WAIT -> exactly 2 writes; no done and no error; words_written=2. A new start is then accepted.
- Reset and ignored inputs:
  - reset=0 asserted during WRITE of word 5 -> all outputs 0 at the next edge; no further writes.
  - start pulsed while busy -> ignored; the original load completes unchanged.

Source files
------------

// File: rtl/program_loader_pkg.sv
// -----------------------------------------------------------------------------
// program_loader_pkg
// Shared definitions for the program loader and the instruction memory store
// port: FSM state encoding, write-control codes and default sizing.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package program_loader_pkg;

    // Loader FSM states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    // Instruction-memory write-control codes (shared with the memory).
    localparam logic [2:0] WR_NONE  = 3'b000;
    localparam logic [2:0] WR_INSTR = 3'b001;

    // Default sizing.
    localparam int DEFAULT_MEM_DEPTH      = 201;
    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/program_loader_timeout_timer.sv
// -----------------------------------------------------------------------------
// loader_timeout_timer
// Counts cycles spent waiting for disk data. The count is cleared by 'clear'
// and advanced by 'enable'. 'expired' is raised in the enabled cycle that would
// bring the number of waited cycles up to TIMEOUT_CYCLES, so the owner can
// leave its wait state on exactly the TIMEOUT_CYCLES-th idle wait cycle.
//
// Ports:
//   clock    in   system clock
//   reset    in   synchronous active-low reset
//   clear    in   restart the count at zero
//   enable   in   one more cycle has been waited
//   expired  out  timeout reached in this cycle
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module loader_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    // 'count' holds the number of idle wait cycles already completed.
    assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
// Copies a program image word by word from disk storage into instruction
// memory. Each word takes a disk request (REQ), a wait for the data (WAIT)
// and a one-cycle store (WRITE).
//
// Disk handshake: hd_read_en is a one-cycle request carrying hd_addr; the disk
// answers later with a one-cycle hd_valid carrying hd_data. Only one request
// is outstanding at a time, and hd_valid is looked at only while in WAIT.
//
// Ports:
//   clock, reset          clock and synchronous active-low reset
//   start, abort          load request (sampled in IDLE) / cancel
//   src_addr, dst_addr    first disk / instruction-memory address
//   num_words             number of words to copy
//   hd_read_en, hd_addr   disk read request and address
//   hd_data, hd_valid     disk read response
//   instr_data/addr       store data and address (hold last values)
//   instr_wr_ctrl         WR_INSTR during WRITE, WR_NONE otherwise
//   busy, done, error     status; done/error are one-cycle pulses
//   words_written         words stored by the current or last load
//   fsm_state             current FSM state, for observation
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module program_loader
    import program_loader_pkg::*;
#(
    parameter int MEM_DEPTH      = DEFAULT_MEM_DEPTH,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] src_addr,
    input  logic [31:0] dst_addr,
    input  logic [15:0] num_words,
    output logic        hd_read_en,
    output logic [31:0] hd_addr,
    input  logic [31:0] hd_data,
    input  logic        hd_valid,
    output logic [31:0] instr_data,
    output logic [31:0] instr_addr,
    output logic [2:0]  instr_wr_ctrl,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] words_written,
    output state_t      fsm_state
);

    state_t      state;
    state_t      state_next;
    logic [31:0] src_q;
    logic [31:0] dst_q;
    logic [15:0] remaining_q;
    logic [15:0] words_q;
    logic [31:0] data_q;
    logic [31:0] addr_q;
    logic        timer_clear;
    logic        timer_enable;
    logic        timer_expired;
    logic        out_of_bounds;
    logic        accept;

    // Widened to 33 bits so a destination near the top of the address space
    // cannot wrap and slip past the check.
    assign out_of_bounds = ({1'b0, dst_addr} + {17'd0, num_words}) > 33'(MEM_DEPTH);
    assign accept        = (state == ST_IDLE) && start && !abort;

    assign timer_clear  = (state == ST_REQ);
    assign timer_enable = (state == ST_WAIT) && !hd_valid;

    loader_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Abort takes priority over every other exit from the
    // active states, including a start seen in the same cycle in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (num_words == 16'd0) begin
                        state_next = ST_DONE;
                    end else if (out_of_bounds) begin
                        state_next = ST_ERR;
                    end else begin
                        state_next = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                state_next = abort ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (hd_valid) begin
                    state_next = ST_WRITE;
                end else if (timer_expired) begin
                    state_next = ST_ERR;
                end
            end
            ST_WRITE: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (remaining_q == 16'd1) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_REQ;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            ST_ERR:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            src_q       <= '0;
            dst_q       <= '0;
            remaining_q <= '0;
            words_q     <= '0;
            data_q      <= '0;
            addr_q      <= '0;
        end else begin
            if (accept) begin
                src_q       <= src_addr;
                dst_q       <= dst_addr;
                remaining_q <= num_words;
                words_q     <= '0;
            end
            // Store data/address are loaded when the word arrives so they are
            // stable during WRITE and then hold until the next word.
            if ((state == ST_WAIT) && hd_valid && !abort) begin
                data_q <= hd_data;
                addr_q <= dst_q;
            end
            // The store in WRITE always lands, even when aborted, so it is
            // always counted.
            if (state == ST_WRITE) begin
                src_q       <= src_q + 32'd1;
                dst_q       <= dst_q + 32'd1;
                remaining_q <= remaining_q - 16'd1;
                words_q     <= words_q + 16'd1;
            end
        end
    end

    assign hd_read_en    = (state == ST_REQ);
    assign hd_addr       = src_q;
    assign instr_data    = data_q;
    assign instr_addr    = addr_q;
    assign instr_wr_ctrl = (state == ST_WRITE) ? WR_INSTR : WR_NONE;
    assign busy          = (state != ST_IDLE);
    assign done          = (state == ST_DONE);
    assign error         = (state == ST_ERR);
    assign words_written = words_q;
    assign fsm_state     = state;

endmodule

// File: tb/tb_program_loader.sv
`timescale 1ns/1ps
module tb_program_loader;
  import program_loader_pkg::*;

  localparam int MEM_DEPTH = 201;
  localparam int TIMEOUT   = 8;

  // ---------------- clock / reset / signals ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] num_words = '0;
  logic        hd_read_en;
  logic [31:0] hd_addr;
  logic [31:0] hd_data = '0;
  logic        hd_valid = 1'b0;
  logic [31:0] instr_data;
  logic [31:0] instr_addr;
  logic [2:0]  instr_wr_ctrl;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_written;
  state_t      fsm_state;

  always #5 clock = ~clock;

  program_loader #(
    .MEM_DEPTH      (MEM_DEPTH),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .src_addr      (src_addr),
    .dst_addr      (dst_addr),
    .num_words     (num_words),
    .hd_read_en    (hd_read_en),
    .hd_addr       (hd_addr),
    .hd_data       (hd_data),
    .hd_valid      (hd_valid),
    .instr_data    (instr_data),
    .instr_addr    (instr_addr),
    .instr_wr_ctrl (instr_wr_ctrl),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .words_written (words_written),
    .fsm_state     (fsm_state)
  );

  // ---------------- disk model: answers one cycle after a request ----------------
  bit disk_on = 1'b1;

  always @(posedge clock) begin
    if (hd_read_en && disk_on) begin
      hd_valid <= 1'b1;
      hd_data  <= 32'hA000_0000 + hd_addr;
    end else begin
      hd_valid <= 1'b0;
    end
  end

  // ---------------- monitor / logs ----------------
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] exp_q[$];
  int rd_count;
  int done_count;
  int err_count;

  always @(negedge clock) begin
    if (instr_wr_ctrl == WR_INSTR) begin
      wr_addr_q.push_back(instr_addr);
      wr_data_q.push_back(instr_data);
    end
    if (hd_read_en) rd_count++;
    if (done) done_count++;
    if (error) err_count++;
  end

  int checks = 0;
  int passed = 0;

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    exp_q.delete();
    rd_count   = 0;
    done_count = 0;
    err_count  = 0;
  endtask

  // Returns one tick after the edge that samples start (the "start edge").
  task automatic start_load(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    @(posedge clock); #1;
    src_addr  = s;
    dst_addr  = d;
    num_words = n;
    start     = 1'b1;
    @(posedge clock); #1;
    start     = 1'b0;
  endtask

  // Cycle number (1 = cycle after start edge) in which done or error is high; 0 if none.
  task automatic wait_end(input int limit, output int cyc, output bit got_done, output bit got_err);
    cyc = 0; got_done = 0; got_err = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clock);
      if (done || error) begin
        cyc = i; got_done = done; got_err = error;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else passed++;
    checks++; if (done !== 1'b0 || error !== 1'b0) $display("FAIL reset_done_err got %0b%0b want 00", done, error); else passed++;
    checks++; if (instr_wr_ctrl !== 3'b000) $display("FAIL reset_wr_ctrl got %0b want 000", instr_wr_ctrl); else passed++;
    checks++; if (hd_read_en !== 1'b0) $display("FAIL reset_read_en got %0b want 0", hd_read_en); else passed++;
    checks++; if (words_written !== 16'd0) $display("FAIL reset_words got %0d want 0", words_written); else passed++;
    checks++; if (instr_addr !== 32'd0 || instr_data !== 32'd0 || hd_addr !== 32'd0)
      $display("FAIL reset_buses got %h/%h/%h want 0", instr_addr, instr_data, hd_addr); else passed++;
    reset = 1'b1;
  endtask

  task automatic test_basic();
    int cyc; bit gd, ge;
    clear_logs();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hA000_0064 + 32'(i));
    start_load(32'd100, 32'd0, 16'd4);
    wait_end(40, cyc, gd, ge);
    @(posedge clock); #1;
    checks++; if (cyc !== 13 || gd !== 1'b1) $display("FAIL basic_done_cycle got %0d (done=%0b) want 13", cyc, gd); else passed++;
    checks++; if (wr_addr_q.size() !== 4) $display("FAIL basic_write_count got %0d want 4", wr_addr_q.size()); else passed++;
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      checks++; if (wr_addr_q[i] !== 32'(i) || wr_data_q[i] !== e)
        $display("FAIL basic_write%0d got %h@%0d want %h@%0d", i, wr_data_q[i], wr_addr_q[i], e, i); else passed++;
    end
    checks++; if (words_written !== 16'd4) $display("FAIL basic_words got %0d want 4", words_written); else passed++;
    checks++; if (rd_count !== 4 || err_count !== 0 || done_count !== 1)
      $display("FAIL basic_counts got rd=%0d err=%0d done=%0d want 4/0/1", rd_count, err_count, done_count); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL basic_idle got busy=%0b want 0", busy); else passed++;
  endtask

  task automatic test_zero_length();
    int cyc; bit gd, ge;
    clear_logs();
    start_load(32'd5, 32'd3, 16'd0);
    wait_end(10, cyc, gd, ge);
    @(posedge clock); #1;
    checks++; if (cyc !== 1 || gd !== 1'b1) $display("FAIL zero_done_cycle got %0d want 1", cyc); else passed++;
    checks++; if (rd_count !== 0 || wr_addr_q.size() !== 0)
      $display("FAIL zero_activity got rd=%0d wr=%0d want 0/0", rd_count, wr_addr_q.size()); else passed++;
    checks++; if (words_written !== 16'd0) $display("FAIL zero_words got %0d want 0", words_written); else passed++;
  endtask

  task automatic test_bounds();
    int cyc; bit gd, ge;
    clear_logs();
    start_load(32'd0, 32'd198, 16'd4);
    wait_end(10, cyc, gd, ge);
    @(posedge clock); #1;
    checks++; if (cyc !== 1 || ge !== 1'b1) $display("FAIL bounds_err_cycle got %0d (err=%0b) want 1", cyc, ge); else passed++;
    checks++; if (wr_addr_q.size() !== 0 || rd_count !== 0)
      $display("FAIL bounds_no_writes got wr=%0d rd=%0d want 0/0", wr_addr_q.size(), rd_count); else passed++;
    clear_logs();
    start_load(32'd0, 32'd197, 16'd4);
    wait_end(40, cyc, gd, ge);
    @(posedge clock); #1;
    checks++; if (cyc !== 13 || gd !== 1'b1) $display("FAIL bounds_fit_done got %0d want 13", cyc); else passed++;
    checks++; if (wr_addr_q.size() !== 4) $display("FAIL bounds_fit_count got %0d want 4", wr_addr_q.size());
    else if (wr_addr_q[3] !== 32'd200 || wr_data_q[3] !== 32'hA000_0003)
      $display("FAIL bounds_fit_last got %h@%0d want a0000003@200", wr_data_q[3], wr_addr_q[3]);
    else passed++;
  endtask

  task automatic test_timeout();
    int cyc; bit gd, ge;
    clear_logs();
    disk_on = 1'b0;
    start_load(32'd0, 32'd0, 16'd1);
    wait_end(40, cyc, gd, ge);
    @(posedge clock); #1;
    disk_on = 1'b1;
    // REQ in cycle 1, eight WAIT cycles 2..9, ERR in cycle 10.
    checks++; if (cyc !== 10 || ge !== 1'b1) $display("FAIL timeout_err_cycle got %0d (err=%0b) want 10", cyc, ge); else passed++;
    checks++; if (wr_addr_q.size() !== 0 || done_count !== 0)
      $display("FAIL timeout_no_write got wr=%0d done=%0d want 0/0", wr_addr_q.size(), done_count); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL timeout_idle got busy=%0b want 0", busy); else passed++;
  endtask

  task automatic test_abort();
    int cyc; bit gd, ge;
    clear_logs();
    start_load(32'd0, 32'd0, 16'd10);
    // Word 3: REQ in cycle 7, WAIT in cycle 8.
    repeat (7) @(posedge clock);
    #1 abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    checks++; if (busy !== 1'b0 || fsm_state !== ST_IDLE) $display("FAIL abort_to_idle got busy=%0b state=%0d want 0/IDLE", busy, fsm_state); else passed++;
    repeat (3) @(posedge clock); #1;
    checks++; if (wr_addr_q.size() !== 2) $display("FAIL abort_writes got %0d want 2", wr_addr_q.size()); else passed++;
    checks++; if (words_written !== 16'd2) $display("FAIL abort_words got %0d want 2", words_written); else passed++;
    checks++; if (done_count !== 0 || err_count !== 0)
      $display("FAIL abort_no_pulse got done=%0d err=%0d want 0/0", done_count, err_count); else passed++;
    clear_logs();
    start_load(32'd7, 32'd5, 16'd1);
    wait_end(20, cyc, gd, ge);
    @(posedge clock); #1;
    checks++; if (cyc !== 4 || gd !== 1'b1) $display("FAIL abort_restart_done got %0d want 4", cyc); else passed++;
    checks++; if (wr_addr_q.size() !== 1) $display("FAIL abort_restart_count got %0d want 1", wr_addr_q.size());
    else if (wr_addr_q[0] !== 32'd5 || wr_data_q[0] !== 32'hA000_0007)
      $display("FAIL abort_restart_write got %h@%0d want a0000007@5", wr_data_q[0], wr_addr_q[0]);
    else passed++;
  endtask

  task automatic test_abort_start_idle();
    clear_logs();
    @(posedge clock); #1;
    src_addr = 32'd0; dst_addr = 32'd0; num_words = 16'd2;
    start = 1'b1; abort = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL abort_start_idle got busy=%0b want 0", busy); else passed++;
    repeat (4) @(posedge clock); #1;
    checks++; if (rd_count !== 0) $display("FAIL abort_start_reads got %0d want 0", rd_count); else passed++;
  endtask

  task automatic test_start_while_busy();
    int cyc; bit gd, ge;
    clear_logs();
    start_load(32'd50, 32'd20, 16'd3);
    repeat (2) @(posedge clock);
    #1;
    src_addr = 32'd0; dst_addr = 32'd100; num_words = 16'd1; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_end(40, cyc, gd, ge);
    @(posedge clock); #1;
    // Three cycles already elapsed after the start edge.
    checks++; if (cyc + 3 !== 10 || gd !== 1'b1) $display("FAIL busy_start_done got %0d want 10", cyc + 3); else passed++;
    checks++; if (wr_addr_q.size() !== 3) $display("FAIL busy_start_count got %0d want 3", wr_addr_q.size()); else passed++;
    for (int i = 0; i < 3 && i < wr_addr_q.size(); i++) begin
      checks++; if (wr_addr_q[i] !== 32'(20 + i) || wr_data_q[i] !== 32'hA000_0032 + 32'(i))
        $display("FAIL busy_start_write%0d got %h@%0d want %h@%0d", i, wr_data_q[i], wr_addr_q[i], 32'hA000_0032 + 32'(i), 20 + i); else passed++;
    end
    checks++; if (done_count !== 1 || words_written !== 16'd3)
      $display("FAIL busy_start_final got done=%0d words=%0d want 1/3", done_count, words_written); else passed++;
  endtask

  task automatic test_reset_mid_load();
    int seen;
    clear_logs();
    seen = 0;
    start_load(32'd0, 32'd10, 16'd8);
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (instr_wr_ctrl == WR_INSTR) seen++;
      if (seen == 5) break;
    end
    checks++; if (seen !== 5) $display("FAIL rst_mid_reach got %0d want 5", seen); else passed++;
    reset = 1'b0;
    @(posedge clock); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || hd_read_en !== 1'b0)
      $display("FAIL rst_mid_ctrl got busy=%0b done=%0b err=%0b rd=%0b want 0", busy, done, error, hd_read_en); else passed++;
    checks++; if (instr_wr_ctrl !== 3'b000 || words_written !== 16'd0)
      $display("FAIL rst_mid_wr got ctrl=%0b words=%0d want 0/0", instr_wr_ctrl, words_written); else passed++;
    checks++; if (instr_addr !== 32'd0 || instr_data !== 32'd0 || hd_addr !== 32'd0)
      $display("FAIL rst_mid_buses got %h/%h/%h want 0", instr_addr, instr_data, hd_addr); else passed++;
    reset = 1'b1;
    repeat (20) @(posedge clock); #1;
    checks++; if (wr_addr_q.size() !== 5 || done_count !== 0 || busy !== 1'b0)
      $display("FAIL rst_mid_after got wr=%0d done=%0d busy=%0b want 5/0/0", wr_addr_q.size(), done_count, busy); else passed++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_zero_length();
    test_bounds();
    test_timeout();
    test_abort();
    test_abort_start_idle();
    test_start_while_busy();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
